clk_monitor: RTL

CLK_MONITOR -- requirements
Module: clk_monitor

---
 rtl/clk_monitor.sv | 100 ++++++++++
 1 files changed

// File: rtl/clk_monitor.sv
// Measures the period and high time of an asynchronous clock in system-clock cycles.
// Flags periods outside a programmable window and detects a stopped clock.
module clk_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             mon_i,
  input  logic [CNT_W-1:0] min_period_i,
  input  logic [CNT_W-1:0] max_period_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             err_o,
  output logic             stuck_o,
  output logic             stuck_lvl_o
);

  typedef enum logic [1:0] {IDLE, SYNC, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic             rise, fall, out_rng;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign out_rng = (cnt < min_period_i) || (cnt > max_period_i);

  // s1/s2 resolve metastability; s3 is the edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      period_o    <= '0;
      high_o      <= '0;
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      stuck_o     <= 1'b0;
      stuck_lvl_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (!en_i) begin
        state   <= IDLE;
        cnt     <= '0;
        stuck_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SYNC;
            cnt   <= '0;
          end
          SYNC, MEASURE: begin
            if (state == MEASURE && fall) high_o <= cnt;
            // A rise in the timeout cycle wins, so cnt tops out at TIMEOUT.
            if (rise) begin
              if (state == MEASURE) begin
                period_o <= cnt;
                valid_o  <= 1'b1;
                err_o    <= out_rng;
              end
              state   <= MEASURE;
              cnt     <= CNT_W'(1);
              stuck_o <= 1'b0;
            end else if (cnt == TO) begin
              state       <= SYNC;
              cnt         <= CNT_W'(1);
              stuck_o     <= 1'b1;
              stuck_lvl_o <= s2;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
